sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
// - Synchronous front-end for the async sram block: turns one-request-at-a-time valid/ready transactions into ADDR/N_WE/N_OE/IN_DATA strobe sequences.
// - Sits directly upstream of sram; its SRAM_* outputs wire straight to sram ADDR/N_WE/N_OE/IN_DATA, and sram OUT_DATA returns on SRAM_RDATA.
// - Guarantees the sram contract: N_OE and N_WE are never low together. All strobes are registered, so they are glitch-free.
// PARAMETERS
// - DEPTH      2  address width in bits (sram holds 1<<DEPTH words)
// - WIDTH      8  data width in bits
// - WE_CYCLES  1  clocks N_WE is held low per write; must be >=1
// - RD_CYCLES  1  clocks N_OE is held low before read capture; must be >=1
// PORTS
// - CLK         in   1      system clock; all state changes on posedge
// - N_RST       in   1      reset, synchronous, active-high
// - REQ_VALID   in   1      request present
// - REQ_READY   out  1      controller can accept a request this cycle
// - REQ_WR      in   1      1=write, 0=read
// - REQ_ADDR    in   DEPTH  request address
// - REQ_WDATA   in   WIDTH  write data
// - RSP_VALID   out  1      one-cycle completion pulse (reads and writes)
// - RSP_RDATA   out  WIDTH  read data; valid when RSP_VALID is high after a read
// - SRAM_ADDR   out  DEPTH  to sram ADDR
// - SRAM_WDATA  out  WIDTH  to sram IN_DATA
// - SRAM_N_WE   out  1      to sram N_WE; write commits on its falling edge
// - SRAM_N_OE   out  1      to sram N_OE
// - SRAM_RDATA  in   WIDTH  from sram OUT_DATA
// BEHAVIOUR
// - Reset (N_RST=1 at posedge): state=IDLE, SRAM_N_WE=1, SRAM_N_OE=1, SRAM_ADDR=0, SRAM_WDATA=0, RSP_RDATA=0, RSP_VALID=0, cycle counter=0.
// - Reset takes effect in the next cycle and overrides any in-flight state. A write aborted in W_PULSE has already committed: N_WE fell earlier.
// - States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_DONE. REQ_READY=1 only in IDLE, combinationally from state.
// - Accept = REQ_VALID && REQ_READY at posedge. On accept, latch REQ_ADDR into SRAM_ADDR and REQ_WDATA into SRAM_WDATA.
//   - Write accept goes to W_SETUP; read accept goes to R_ACCESS.
//   - SRAM_ADDR/SRAM_WDATA do not change outside an accept edge.
// - W_SETUP: 1 cycle, N_WE=1. Address and data are stable before N_WE falls.
// - W_PULSE: WE_CYCLES cycles, N_WE=0.
// - W_HOLD: 1 cycle, N_WE=1, address and data held, RSP_VALID=1. Next state is IDLE.
// - Write latency: accept edge to RSP_VALID high = WE_CYCLES+2 cycles.
// - R_ACCESS: RD_CYCLES cycles, N_OE=0. At the final edge of R_ACCESS, SRAM_RDATA is captured into RSP_RDATA and N_OE returns to 1.
// - R_DONE: 1 cycle, N_OE=1, RSP_VALID=1. Next state is IDLE.
// - Read latency: accept edge to RSP_VALID high = RD_CYCLES+1 cycles.
// - RSP_RDATA holds its last read value until the next read capture. Writes do not alter it.
// - N_WE=0 only in W_PULSE; N_OE=0 only in R_ACCESS. Both are high in every other state.
// - The cycle counter is $clog2(max(WE_CYCLES,RD_CYCLES))+1 bits wide, reloads on state entry, and never wraps.
// - REQ_VALID while not ready is ignored; the requester holds the request. No queueing.
// - Address wrap is inherent: REQ_ADDR is exactly DEPTH bits and all 1<<DEPTH addresses are legal.
// CONFIGURATION
// - SRAM_CTRL_B2B_EN defined:
//   - REQ_READY is also 1 in W_HOLD and R_DONE.
//   - An accept in those states jumps directly to W_SETUP/R_ACCESS, saving 1 cycle per back-to-back op.
//   - Address/data update at that edge; this is safe because N_WE and N_OE are already high.
// - SRAM_CTRL_B2B_EN undefined: REQ_READY is 1 only in IDLE, as above.
// - Formal builds assert that (SRAM_N_WE || SRAM_N_OE) holds whenever N_RST=0, in both configurations.
// TESTING
// - Write 0xA5 to addr 2 -> SRAM_ADDR=2, data=0xA5, N_WE low for exactly 1 cycle after 1 setup cycle; RSP_VALID 3 cycles after accept; sram mem[2]=0xA5.
// - Read addr 2 after that write -> N_OE low 1 cycle; RSP_VALID 2 cycles after accept with RSP_RDATA=0xA5; N_WE stays 1 throughout.
// - WE_CYCLES=3, RD_CYCLES=2: write 0x3C to addr 3, then read addr 3 -> N_WE low 3 cycles, N_OE low 2 cycles, RSP_RDATA=0x3C.
// - N_RST pulsed during W_PULSE -> next cycle N_WE=1, N_OE=1, REQ_READY=1, no RSP_VALID. A later read of that addr returns the new data.
// - REQ_VALID held high with alternating write/read ops for 50 random ops -> (N_WE||N_OE) never low together; every read matches a shadow model.
// - SRAM_CTRL_B2B_EN: write addr 0 then read addr 0 back-to-back -> read accepted in the W_HOLD cycle; RSP_RDATA matches the written data; total 1 cycle shorter than without the macro.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Request/response and sram-side bus between a requester, sram_ctrl and the async sram.
// The controller takes the slave modport; the requester/sram side takes master.
interface sram_ctrl_if #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WR;
  logic [DEPTH-1:0] REQ_ADDR;
  logic [WIDTH-1:0] REQ_WDATA;
  logic             RSP_VALID;
  logic [WIDTH-1:0] RSP_RDATA;
  logic [DEPTH-1:0] SRAM_ADDR;
  logic [WIDTH-1:0] SRAM_WDATA;
  logic             SRAM_N_WE;
  logic             SRAM_N_OE;
  logic [WIDTH-1:0] SRAM_RDATA;

  modport slave (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, SRAM_RDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, SRAM_ADDR, SRAM_WDATA, SRAM_N_WE, SRAM_N_OE
  );

  modport master (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, SRAM_RDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, SRAM_ADDR, SRAM_WDATA, SRAM_N_WE, SRAM_N_OE
  );
endinterface

// File: rtl/sram_ctrl.sv
// Valid/ready front-end that sequences registered ADDR/N_WE/N_OE strobes for the async sram.
// Define SRAM_CTRL_B2B_EN to also accept requests in W_HOLD/R_DONE (back-to-back ops).
module sram_ctrl #(
  parameter int DEPTH     = 2,
  parameter int WIDTH     = 8,
  parameter int WE_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input logic       CLK,
  input logic       N_RST,
  sram_ctrl_if.slave bus
);
  localparam int MAX_CYCLES = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req_ready, accept, capture;
  logic             n_we, n_oe, rsp_valid;
  logic [DEPTH-1:0] addr;
  logic [WIDTH-1:0] wdata, rdata;

`ifdef SRAM_CTRL_B2B_EN
  assign req_ready = (state == IDLE) || (state == W_HOLD) || (state == R_DONE);
`else
  assign req_ready = (state == IDLE);
`endif

  assign accept  = bus.REQ_VALID && req_ready;
  assign capture = (state == R_ACCESS) && (cnt == '0);

  // Counter holds the remaining cycles of a multi-cycle state; it is reloaded on entry only.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE:     state_next = IDLE;
      W_SETUP: begin
        state_next = W_PULSE;
        cnt_next   = WE_LOAD;
      end
      W_PULSE: begin
        if (cnt == '0) state_next = W_HOLD;
        else           cnt_next   = cnt - 1'b1;
      end
      R_ACCESS: begin
        if (cnt == '0) state_next = R_DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      W_HOLD, R_DONE: state_next = IDLE;
      default:        state_next = IDLE;
    endcase
    if (accept) begin
      if (bus.REQ_WR) begin
        state_next = W_SETUP;
        cnt_next   = '0;
      end else begin
        state_next = R_ACCESS;
        cnt_next   = RD_LOAD;
      end
    end
  end

  // Strobes are decoded from the next state so they leave a flop and never glitch.
  always_ff @(posedge CLK) begin
    if (N_RST) begin
      state     <= IDLE;
      cnt       <= '0;
      n_we      <= 1'b1;
      n_oe      <= 1'b1;
      rsp_valid <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      n_we      <= (state_next != W_PULSE);
      n_oe      <= (state_next != R_ACCESS);
      rsp_valid <= (state_next == W_HOLD) || (state_next == R_DONE);
      if (accept) begin
        addr  <= bus.REQ_ADDR;
        wdata <= bus.REQ_WDATA;
      end
      if (capture) rdata <= bus.SRAM_RDATA;
    end
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.RSP_VALID  = rsp_valid;
  assign bus.RSP_RDATA  = rdata;
  assign bus.SRAM_ADDR  = addr;
  assign bus.SRAM_WDATA = wdata;
  assign bus.SRAM_N_WE  = n_we;
  assign bus.SRAM_N_OE  = n_oe;

`ifdef FORMAL
  always @(posedge CLK) begin
    if (!N_RST) assert (bus.SRAM_N_WE || bus.SRAM_N_OE);
  end
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a cycle-timeline model of DUT A (WE=1,RD=1) checked every cycle,
// plus directed literal checks on A and on a second instance B (WE=3,RD=2).
module tb_sram_ctrl;
  localparam int WE_A = 1, RD_A = 1, WE_B = 3, RD_B = 2;
  localparam int LAT_W = WE_A + 2, LAT_R = RD_A + 1;
`ifdef SRAM_CTRL_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic CLK = 1'b0;
  logic N_RST = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   model_on = 1'b0;

  sram_ctrl_if #(.DEPTH(2), .WIDTH(8)) bus_a ();
  sram_ctrl_if #(.DEPTH(2), .WIDTH(8)) bus_b ();

  sram_ctrl #(.DEPTH(2), .WIDTH(8), .WE_CYCLES(WE_A), .RD_CYCLES(RD_A)) dut (
    .CLK(CLK), .N_RST(N_RST), .bus(bus_a));
  sram_ctrl #(.DEPTH(2), .WIDTH(8), .WE_CYCLES(WE_B), .RD_CYCLES(RD_B)) dut_b (
    .CLK(CLK), .N_RST(N_RST), .bus(bus_b));

  always #5 CLK = ~CLK;

  // Async sram stand-ins: commit on the falling edge of N_WE, drive data only while N_OE is low.
  logic [7:0] mem_a [4] = '{default: 8'h00};
  logic [7:0] mem_b [4] = '{default: 8'h00};
  always @(negedge bus_a.SRAM_N_WE) mem_a[bus_a.SRAM_ADDR] = bus_a.SRAM_WDATA;
  always @(negedge bus_b.SRAM_N_WE) mem_b[bus_b.SRAM_ADDR] = bus_b.SRAM_WDATA;
  assign bus_a.SRAM_RDATA = bus_a.SRAM_N_OE ? 8'hxx : mem_a[bus_a.SRAM_ADDR];
  assign bus_b.SRAM_RDATA = bus_b.SRAM_N_OE ? 8'hxx : mem_b[bus_b.SRAM_ADDR];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Timeline model: an op accepted at cycle r owns the strobes for the following LAT cycles.
  int         cyc = 0;
  int         op_r = 0;
  bit         op_act = 1'b0, op_wr = 1'b0, pend_reset = 1'b0;
  logic [1:0] op_addr = '0, exp_addr = '0;
  logic [7:0] op_data = '0, exp_wdata = '0, exp_rdata = '0;
  logic [7:0] shadow [4] = '{default: 8'h00};

  always @(negedge CLK) begin
    int d, lat;
    bit e_rsp, e_nwe, e_noe, e_ready;
    if (model_on) begin
      cyc++;
      if (pend_reset) begin
        op_act = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; pend_reset = 1'b0;
      end
      d   = cyc - op_r;
      lat = op_wr ? LAT_W : LAT_R;
      if (op_act && d > lat) op_act = 1'b0;
      e_rsp   = op_act && (d == lat);
      e_nwe   = !(op_act && op_wr && d >= 2 && d <= WE_A + 1);
      e_noe   = !(op_act && !op_wr && d >= 1 && d <= RD_A);
      e_ready = !op_act || (B2B && e_rsp);
      if (op_act && op_wr && d == 2) shadow[op_addr] = op_data;
      if (e_rsp && !op_wr) exp_rdata = shadow[op_addr];
      checkOutput("req_ready", bus_a.REQ_READY, e_ready);
      checkOutput("n_we", bus_a.SRAM_N_WE, e_nwe);
      checkOutput("n_oe", bus_a.SRAM_N_OE, e_noe);
      checkOutput("rsp_valid", bus_a.RSP_VALID, e_rsp);
      checkOutput("sram_addr", bus_a.SRAM_ADDR, exp_addr);
      checkOutput("sram_wdata", bus_a.SRAM_WDATA, exp_wdata);
      checkOutput("rsp_rdata", bus_a.RSP_RDATA, exp_rdata);
      checkOutput("strobe_overlap", bus_a.SRAM_N_WE | bus_a.SRAM_N_OE, 1);
      if (N_RST) pend_reset = 1'b1;
      else if (bus_a.REQ_VALID && e_ready) begin
        op_act = 1'b1; op_r = cyc; op_wr = bus_a.REQ_WR;
        op_addr = bus_a.REQ_ADDR; op_data = bus_a.REQ_WDATA;
        exp_addr = op_addr; exp_wdata = op_data;
      end
    end
  end

  task automatic driveReq(input bit on_b, input bit valid, input bit wr,
                          input logic [1:0] addr, input logic [7:0] data);
    if (on_b) begin
      bus_b.REQ_VALID = valid; bus_b.REQ_WR = wr; bus_b.REQ_ADDR = addr; bus_b.REQ_WDATA = data;
    end else begin
      bus_a.REQ_VALID = valid; bus_a.REQ_WR = wr; bus_a.REQ_ADDR = addr; bus_a.REQ_WDATA = data;
    end
  endtask

  // {ready, n_we, n_oe, rsp_valid} of the selected instance
  function automatic logic [3:0] status(input bit on_b);
    return on_b ? {bus_b.REQ_READY, bus_b.SRAM_N_WE, bus_b.SRAM_N_OE, bus_b.RSP_VALID}
                : {bus_a.REQ_READY, bus_a.SRAM_N_WE, bus_a.SRAM_N_OE, bus_a.RSP_VALID};
  endfunction

  // One request; lat counts cycles from the accept cycle to the RSP_VALID cycle.
  task automatic applyStimulus(input bit on_b, input bit wr, input logic [1:0] addr,
                               input logic [7:0] data, output int lat, output logic [7:0] rdata,
                               output int nwe_lo, output int noe_lo);
    int n;
    logic [3:0] st;
    @(posedge CLK); #1;
    driveReq(on_b, 1'b1, wr, addr, data);
    n = 0;
    do begin @(negedge CLK); n++; end while (status(on_b)[3] !== 1'b1 && n < 50);
    if (status(on_b)[3] !== 1'b1) checkOutput("accept_timeout", status(on_b)[3], 1);
    @(posedge CLK); #1;
    driveReq(on_b, 1'b0, wr, addr, data);
    lat = 0; nwe_lo = 0; noe_lo = 0;
    do begin
      @(negedge CLK);
      lat++;
      st = status(on_b);
      if (st[2] === 1'b0) nwe_lo++;
      if (st[1] === 1'b0) noe_lo++;
      checkOutput("op_overlap", st[2] | st[1], 1);
    end while (st[0] !== 1'b1 && lat < 50);
    rdata = on_b ? bus_b.RSP_RDATA : bus_a.RSP_RDATA;
  endtask

  // REQ_VALID held high; alternating write/read with random address and data.
  task automatic streamOps(input int count);
    int done, guard;
    done = 0; guard = 0;
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    while (done < count && guard < 2000) begin
      @(negedge CLK);
      guard++;
      if (bus_a.REQ_READY === 1'b1) begin
        done++;
        @(posedge CLK); #1;
        driveReq(1'b0, (done < count), (done % 2 == 0),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
    end
    if (done < count) checkOutput("stream_timeout", done, count);
    bus_a.REQ_VALID = 1'b0;
    repeat (8) @(posedge CLK);
  endtask

  initial begin
    int lat, nwe_lo, noe_lo, t, acc_t;
    logic [7:0] rd;
    logic in_hold;
    driveReq(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    driveReq(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge CLK); #1;
    model_on = 1'b1;
    @(negedge CLK);
    checkOutput("rst_ready", bus_a.REQ_READY, 1);
    checkOutput("rst_n_we", bus_a.SRAM_N_WE, 1);
    checkOutput("rst_n_oe", bus_a.SRAM_N_OE, 1);
    checkOutput("rst_rsp_valid", bus_a.RSP_VALID, 0);
    checkOutput("rst_rdata", bus_a.RSP_RDATA, 0);
    @(posedge CLK); #1;
    N_RST = 1'b0;

    $display("[TB] write 0xA5 to addr 2, read it back");
    applyStimulus(1'b0, 1'b1, 2'd2, 8'hA5, lat, rd, nwe_lo, noe_lo);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_nwe_cycles", nwe_lo, 1);
    checkOutput("wr_noe_cycles", noe_lo, 0);
    checkOutput("mem2", mem_a[2], 8'hA5);
    applyStimulus(1'b0, 1'b0, 2'd2, 8'h00, lat, rd, nwe_lo, noe_lo);
    checkOutput("rd_latency", lat, 2);
    checkOutput("rd_data", rd, 8'hA5);
    checkOutput("rd_noe_cycles", noe_lo, 1);
    checkOutput("rd_nwe_cycles", nwe_lo, 0);

    $display("[TB] reset during W_PULSE");
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b1, 1'b1, 2'd1, 8'h5A);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus_a.REQ_READY !== 1'b1 && t < 50);
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge CLK); #1;
    N_RST = 1'b1;
    @(negedge CLK);
    checkOutput("pulse_n_we", bus_a.SRAM_N_WE, 0);
    @(posedge CLK); #1;
    N_RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort_n_we", bus_a.SRAM_N_WE, 1);
    checkOutput("abort_n_oe", bus_a.SRAM_N_OE, 1);
    checkOutput("abort_ready", bus_a.REQ_READY, 1);
    checkOutput("abort_rsp", bus_a.RSP_VALID, 0);
    applyStimulus(1'b0, 1'b0, 2'd1, 8'h00, lat, rd, nwe_lo, noe_lo);
    checkOutput("abort_rd_data", rd, 8'h5A);

    $display("[TB] 50 streamed ops");
    streamOps(50);

    $display("[TB] write then read addr 0 with REQ_VALID held");
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b1, 1'b1, 2'd0, 8'h77);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus_a.REQ_READY !== 1'b1 && t < 50);
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b1, 1'b0, 2'd0, 8'h77);
    t = 0;
    do begin @(negedge CLK); t++; end while (bus_a.REQ_READY !== 1'b1 && t < 50);
    acc_t = t;
    in_hold = bus_a.RSP_VALID;
    @(posedge CLK); #1;
    driveReq(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    do begin @(negedge CLK); t++; end while (bus_a.RSP_VALID !== 1'b1 && t < 100);
    checkOutput("b2b_read_accept", acc_t, B2B ? 3 : 4);
    checkOutput("b2b_in_hold", in_hold, B2B ? 1 : 0);
    checkOutput("b2b_total", t, B2B ? 5 : 6);
    checkOutput("b2b_rdata", bus_a.RSP_RDATA, 8'h77);

    $display("[TB] WE_CYCLES=3 RD_CYCLES=2 instance");
    applyStimulus(1'b1, 1'b1, 2'd3, 8'h3C, lat, rd, nwe_lo, noe_lo);
    checkOutput("b_wr_latency", lat, 5);
    checkOutput("b_nwe_cycles", nwe_lo, 3);
    checkOutput("b_mem3", mem_b[3], 8'h3C);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h00, lat, rd, nwe_lo, noe_lo);
    checkOutput("b_rd_latency", lat, 3);
    checkOutput("b_noe_cycles", noe_lo, 2);
    checkOutput("b_rd_nwe_cycles", nwe_lo, 0);
    checkOutput("b_rd_data", rd, 8'h3C);

    repeat (4) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
